// File: rtl/fight_pkg.sv
// Shared definitions for the fight controller: state codes, option codes,
// skill damage table, LFSR seed and the per-tick HP reduction step.
package fight_pkg;

  // Scene state codes, as seen by the renderer
  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_MENU           = 3'd1,
    ST_CHOOSING_SKILL = 3'd2,
    ST_ANIMATION_P1   = 3'd3,
    ST_ANIMATION_P2   = 3'd4,
    ST_HPREDUCING_P1  = 3'd5,
    ST_HPREDUCING_P2  = 3'd6,
    ST_GAME_OVER      = 3'd7
  } fight_state_e;

  // Option cursor codes on a 2x2 grid: 1 2 / 3 4
  localparam logic [3:0] OPT_1 = 4'd1;
  localparam logic [3:0] OPT_2 = 4'd2;
  localparam logic [3:0] OPT_3 = 4'd3;
  localparam logic [3:0] OPT_4 = 4'd4;

  // Winner codes
  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

  // Power-on value of the P2 skill LFSR
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Result of one HP-reduction tick
  typedef struct packed {
    logic [7:0] hp;
    logic [7:0] dmg;
    logic       ko;    // player HP is (now) zero
    logic       done;  // no damage left to apply
  } hp_step_t;

  // Damage dealt by skill 1..4; anything else deals nothing
  function automatic logic [7:0] skill_damage(input logic [3:0] skill);
    logic [7:0] dmg;
    case (skill)
      OPT_1:   dmg = 8'd10;
      OPT_2:   dmg = 8'd20;
      OPT_3:   dmg = 8'd35;
      OPT_4:   dmg = 8'd50;
      default: dmg = 8'd0;
    endcase
    return dmg;
  endfunction

  // Toggle the grid column (1<->2, 3<->4)
  function automatic logic [3:0] opt_toggle_col(input logic [3:0] opt);
    logic [3:0] idx;
    idx    = opt - 4'd1;
    idx[0] = ~idx[0];
    return {2'b00, idx[1:0]} + 4'd1;
  endfunction

  // Toggle the grid row (1<->3, 2<->4)
  function automatic logic [3:0] opt_toggle_row(input logic [3:0] opt);
    logic [3:0] idx;
    idx    = opt - 4'd1;
    idx[1] = ~idx[1];
    return {2'b00, idx[1:0]} + 4'd1;
  endfunction

  // One tick of HP reduction. A knocked-out player wins over remaining
  // damage; zero remaining damage ends the phase without touching HP.
  function automatic hp_step_t hp_step(input logic [7:0] hp, input logic [7:0] dmg);
    hp_step_t r;
    r.hp   = hp;
    r.dmg  = dmg;
    r.ko   = 1'b0;
    r.done = 1'b0;
    if (hp == 8'd0) begin
      r.ko = 1'b1;
    end else if (dmg == 8'd0) begin
      r.done = 1'b1;
    end else begin
      r.hp   = hp - 8'd1;
      r.dmg  = dmg - 8'd1;
      r.ko   = (r.hp == 8'd0);
      r.done = (r.dmg == 8'd0);
    end
    return r;
  endfunction

endpackage

// File: rtl/fight_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to pick the P2 skill.
// Loads SEED while reset is asserted and shifts on every enabled clock.
module fight_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] lfsr_q
);

  logic [7:0] lfsr_d;
  logic       feedback;

  // Next LFSR value: shift left, feedback from the tap bits into bit 0
  always_comb begin
    feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_d   = lfsr_q;
    if (en) begin
      lfsr_d = {lfsr_q[6:0], feedback};
    end
  end

  // LFSR register, seeded on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/fight_controller.sv
// Turn-based fight scene controller: menu navigation, skill selection,
// tick-paced attack animations and HP drain, winner detection.
// Optional build macro P2_RANDOM_SKILL_EN: P2 skill comes from an LFSR;
// without it P2 mirrors the last P1 skill.
module fight_controller
  import fight_pkg::*;
#(
  parameter int ANIM_TICKS = 30,
  parameter int HP_MAX     = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic [7:0] p1_init_hp,
  input  logic [7:0] p2_init_hp,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_enter,
  output logic [5:0] fight_state,
  output logic [3:0] option_state,
  output logic [7:0] p1_cur_hp,
  output logic [7:0] p2_cur_hp,
  output logic [1:0] winner
);

  localparam int              CNT_W    = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_TICKS - 1);
  localparam logic [7:0]      HP_CAP   = 8'(HP_MAX);

  fight_state_e     state_q,    state_d;
  logic [3:0]       option_q,   option_d;
  logic [7:0]       p1_hp_q,    p1_hp_d;
  logic [7:0]       p2_hp_q,    p2_hp_d;
  logic [1:0]       winner_q,   winner_d;
  logic [CNT_W-1:0] anim_cnt_q, anim_cnt_d;
  logic [7:0]       dmg_q,      dmg_d;
  logic [3:0]       p1_skill_q, p1_skill_d;

  logic [3:0] p2_skill;
  logic [3:0] nav_option;
  hp_step_t   p1_step;
  hp_step_t   p2_step;

`ifdef P2_RANDOM_SKILL_EN
  logic [7:0] lfsr_value;

  fight_lfsr8 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (1'b1),
    .lfsr_q (lfsr_value)
  );

  assign p2_skill = {2'b00, lfsr_value[1:0]} + 4'd1;
`else
  assign p2_skill = p1_skill_q;
`endif

  // Load value for HP, clamped to the full bar width
  function automatic logic [7:0] clamp_hp(input logic [7:0] hp);
    return (hp > HP_CAP) ? HP_CAP : hp;
  endfunction

  // Cursor move from arrow keys; up > down > left > right, one key only
  always_comb begin
    nav_option = option_q;
    if (key_up || key_down) begin
      nav_option = opt_toggle_row(option_q);
    end else if (key_left || key_right) begin
      nav_option = opt_toggle_col(option_q);
    end
  end

  // One reduction tick for each player; only the active phase uses its result
  always_comb begin
    p1_step = hp_step(p1_hp_q, dmg_q);
    p2_step = hp_step(p2_hp_q, dmg_q);
  end

  // Next-state logic for the whole fight sequence
  always_comb begin
    state_d    = state_q;
    option_d   = option_q;
    p1_hp_d    = p1_hp_q;
    p2_hp_d    = p2_hp_q;
    winner_d   = winner_q;
    anim_cnt_d = anim_cnt_q;
    dmg_d      = dmg_q;
    p1_skill_d = p1_skill_q;

    case (state_q)
      ST_IDLE, ST_GAME_OVER: begin
        if (start) begin
          state_d    = ST_MENU;
          option_d   = OPT_1;
          p1_hp_d    = clamp_hp(p1_init_hp);
          p2_hp_d    = clamp_hp(p2_init_hp);
          winner_d   = WIN_NONE;
          anim_cnt_d = '0;
          dmg_d      = 8'd0;
        end
      end

      ST_MENU: begin
        // Enter consumes the cycle even when it selects nothing
        if (key_enter) begin
          if (option_q == OPT_1) begin
            state_d  = ST_CHOOSING_SKILL;
            option_d = OPT_1;
          end
        end else begin
          option_d = nav_option;
        end
      end

      ST_CHOOSING_SKILL: begin
        if (key_enter) begin
          p1_skill_d = option_q;
          dmg_d      = skill_damage(option_q);
          anim_cnt_d = '0;
          state_d    = ST_ANIMATION_P1;
        end else begin
          option_d = nav_option;
        end
      end

      ST_ANIMATION_P1, ST_ANIMATION_P2: begin
        if (tick) begin
          if (anim_cnt_q == CNT_LAST) begin
            anim_cnt_d = '0;
            state_d    = (state_q == ST_ANIMATION_P1) ? ST_HPREDUCING_P2
                                                      : ST_HPREDUCING_P1;
          end else begin
            anim_cnt_d = anim_cnt_q + 1'b1;
          end
        end
      end

      ST_HPREDUCING_P2: begin
        if (tick) begin
          p2_hp_d = p2_step.hp;
          dmg_d   = p2_step.dmg;
          if (p2_step.ko) begin
            state_d  = ST_GAME_OVER;
            winner_d = WIN_P1;
          end else if (p2_step.done) begin
            // P2 picks its counter-attack on entry to its animation
            state_d    = ST_ANIMATION_P2;
            dmg_d      = skill_damage(p2_skill);
            anim_cnt_d = '0;
          end
        end
      end

      ST_HPREDUCING_P1: begin
        if (tick) begin
          p1_hp_d = p1_step.hp;
          dmg_d   = p1_step.dmg;
          if (p1_step.ko) begin
            state_d  = ST_GAME_OVER;
            winner_d = WIN_P2;
          end else if (p1_step.done) begin
            state_d  = ST_MENU;
            option_d = OPT_1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any battle in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      option_q   <= OPT_1;
      p1_hp_q    <= 8'd0;
      p2_hp_q    <= 8'd0;
      winner_q   <= WIN_NONE;
      anim_cnt_q <= '0;
      dmg_q      <= 8'd0;
      p1_skill_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      option_q   <= option_d;
      p1_hp_q    <= p1_hp_d;
      p2_hp_q    <= p2_hp_d;
      winner_q   <= winner_d;
      anim_cnt_q <= anim_cnt_d;
      dmg_q      <= dmg_d;
      p1_skill_q <= p1_skill_d;
    end
  end

  assign fight_state  = {3'b000, state_q};
  assign option_state = option_q;
  assign p1_cur_hp    = p1_hp_q;
  assign p2_cur_hp    = p2_hp_q;
  assign winner       = winner_q;

endmodule

// File: tb/tb_fight_controller.sv
// Directed bench for fight_controller (default build, P2 mirrors P1 skill).
module tb_fight_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [7:0] p1_init_hp = 8'd0;
  logic [7:0] p2_init_hp = 8'd0;
  logic       key_up = 1'b0;
  logic       key_down = 1'b0;
  logic       key_left = 1'b0;
  logic       key_right = 1'b0;
  logic       key_enter = 1'b0;
  logic [5:0] fight_state;
  logic [3:0] option_state;
  logic [7:0] p1_cur_hp;
  logic [7:0] p2_cur_hp;
  logic [1:0] winner;

  int n_checks = 0;
  int n_errors = 0;

  fight_controller #(
    .ANIM_TICKS(30),
    .HP_MAX    (200)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .start        (start),
    .p1_init_hp   (p1_init_hp),
    .p2_init_hp   (p2_init_hp),
    .key_up       (key_up),
    .key_down     (key_down),
    .key_left     (key_left),
    .key_right    (key_right),
    .key_enter    (key_enter),
    .fight_state  (fight_state),
    .option_state (option_state),
    .p1_cur_hp    (p1_cur_hp),
    .p2_cur_hp    (p2_cur_hp),
    .winner       (winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge so outputs are stable
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
  endtask

  task automatic press(input logic up, input logic dn, input logic lf,
                       input logic rt, input logic en);
    key_up = up; key_down = dn; key_left = lf; key_right = rt; key_enter = en;
    cyc();
    key_up = 0; key_down = 0; key_left = 0; key_right = 0; key_enter = 0;
  endtask

  task automatic do_start(input logic [7:0] a, input logic [7:0] b);
    p1_init_hp = a; p2_init_hp = b; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_state", fight_state, 0);
    chk("rst_opt", option_state, 1);
    chk("rst_hp1", p1_cur_hp, 0);
    chk("rst_winner", winner, 0);
    rst_n = 1'b1;
    cyc();

    // Start loads HP and enters MENU
    do_start(8'd100, 8'd100);
    chk("start_state", fight_state, 1);
    chk("start_hp1", p1_cur_hp, 100);
    chk("start_hp2", p2_cur_hp, 100);
    chk("start_opt", option_state, 1);

    // Menu navigation with wrap
    press(0, 0, 0, 1, 0); chk("nav_right", option_state, 2);
    press(0, 1, 0, 0, 0); chk("nav_down", option_state, 4);
    press(0, 0, 1, 0, 0); chk("nav_left", option_state, 3);
    press(0, 0, 0, 0, 1); chk("enter_opt3_state", fight_state, 1);
    chk("enter_opt3_opt", option_state, 3);
    press(1, 0, 0, 0, 0); chk("nav_up", option_state, 1);
    press(0, 0, 0, 0, 1); chk("enter_menu", fight_state, 2);
    chk("choose_opt", option_state, 1);

    // Skill 3 (35 damage), P2 mirrors it
    press(0, 1, 0, 0, 0); chk("choose_down", option_state, 3);
    press(0, 0, 0, 0, 1); chk("skill_latch", fight_state, 3);
    ticks(29);            chk("anim_p1_edge", fight_state, 3);
    ticks(1);             chk("to_hpred_p2", fight_state, 6);
    ticks(1);             chk("p2_first_dec", p2_cur_hp, 99);
    ticks(34);            chk("p2_after35", p2_cur_hp, 65);
    chk("to_anim_p2", fight_state, 4);
    ticks(30);            chk("to_hpred_p1", fight_state, 5);
    ticks(35);            chk("p1_after35", p1_cur_hp, 65);
    chk("back_menu", fight_state, 1);
    chk("back_menu_opt", option_state, 1);

    // Enter and right together: skill from current option, no cursor move
    press(0, 0, 0, 0, 1); chk("menu_to_choose", fight_state, 2);
    press(0, 0, 0, 1, 1); chk("enter_right_state", fight_state, 3);
    chk("enter_right_opt", option_state, 1);
    ticks(30);
    ticks(10);            chk("skill1_p2", p2_cur_hp, 55);
    chk("skill1_state", fight_state, 4);
    ticks(40);            chk("skill1_p1", p1_cur_hp, 55);
    chk("skill1_menu", fight_state, 1);

    // Start ignored outside IDLE/GAME_OVER; tick with a key handled as key
    do_start(8'd7, 8'd7); chk("start_ignored", p1_cur_hp, 55);
    key_right = 1'b1; ticks(1); key_right = 1'b0;
    chk("tick_and_key", option_state, 2);
    chk("tick_and_key_state", fight_state, 1);
    press(0, 0, 1, 0, 0);

    // Reset during HPREDUCING_P2 aborts asynchronously
    press(0, 0, 0, 0, 1);
    press(0, 0, 0, 0, 1);
    ticks(33);            chk("pre_abort_hp2", p2_cur_hp, 52);
    chk("pre_abort_state", fight_state, 6);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_state", fight_state, 0);
    chk("abort_hp1", p1_cur_hp, 0);
    chk("abort_hp2", p2_cur_hp, 0);
    chk("abort_opt", option_state, 1);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Knockout: P2 at 20 HP, P1 skill 4 (50 damage)
    do_start(8'd100, 8'd20);
    chk("ko_start_state", fight_state, 1);
    chk("ko_start_hp2", p2_cur_hp, 20);
    press(0, 0, 0, 0, 1);
    press(0, 1, 0, 0, 0);
    press(0, 0, 0, 1, 0); chk("ko_opt4", option_state, 4);
    press(0, 0, 0, 0, 1);
    ticks(30);
    ticks(19);            chk("ko_hp2_1", p2_cur_hp, 1);
    chk("ko_state_pre", fight_state, 6);
    ticks(1);             chk("ko_hp2_0", p2_cur_hp, 0);
    chk("ko_state", fight_state, 7);
    chk("ko_winner", winner, 1);
    press(1, 0, 0, 0, 0);
    press(0, 0, 0, 0, 1);
    ticks(5);
    chk("go_hold_state", fight_state, 7);
    chk("go_hold_opt", option_state, 4);
    chk("go_hold_hp1", p1_cur_hp, 100);
    chk("go_hold_winner", winner, 1);

    // Restart from GAME_OVER with clamp
    do_start(8'd250, 8'd3);
    chk("restart_state", fight_state, 1);
    chk("restart_clamp", p1_cur_hp, 200);
    chk("restart_hp2", p2_cur_hp, 3);
    chk("restart_winner", winner, 0);
    chk("restart_opt", option_state, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fight_controller.md
FIGHT_CONTROLLER -- requirements
Module: fight_controller

Interface
REQ-001 Parameter ANIM_TICKS, default 30: frame ticks each attack animation state lasts.
REQ-002 Parameter HP_MAX, default 200: upper clamp for loaded HP, equal to the full-width HP bar in pixels.
REQ-003 clk  input  1  system clock; one clock; reset is asynchronous and active-low.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 tick  input  1  one-cycle frame pulse that paces animation and HP decrement.
REQ-006 start  input  1  one-cycle pulse that begins a battle.
REQ-007 p1_init_hp, p2_init_hp  input  8 each  starting HP, sampled on accepted start.
REQ-008 key_up, key_down, key_left, key_right, key_enter  input  1 each  debounced one-cycle pulses.
REQ-009 fight_state  output  6  current state code, consumed by the scene renderer.
REQ-010 option_state  output  4  highlighted option, 1..4 (grid: 1 2 / 3 4).
REQ-011 p1_cur_hp, p2_cur_hp  output  8 each  displayed HP, equal to HP-bar width.
REQ-012 winner  output  2  0 = none, 1 = P1, 2 = P2.

Function
REQ-013 State codes: IDLE=0, MENU=1, CHOOSING_SKILL=2, ANIMATION_P1=3, ANIMATION_P2=4, HPREDUCING_P1=5, HPREDUCING_P2=6, GAME_OVER=7.
REQ-014 start in IDLE or GAME_OVER loads both HP values, clamped to HP_MAX, sets winner=0, option_state=1, and moves to MENU in the next cycle; start in any other state is ignored.
REQ-015 In MENU and CHOOSING_SKILL, left/right toggle the column and up/down toggle the row of option_state, wrapping (1<->2, 3<->4, 1<->3, 2<->4).
REQ-016 Same-cycle key priority is enter > up > down > left > right; only one key acts per cycle.
REQ-017 MENU + enter with option 1 -> CHOOSING_SKILL with option_state reset to 1; enter with options 2-4 is ignored.
REQ-018 CHOOSING_SKILL + enter latches the P1 skill (option_state) and its damage, then moves to ANIMATION_P1.
REQ-019 Keys are ignored in all other states.
REQ-020 Animation states count ANIM_TICKS tick pulses, then move on:
  - ANIMATION_P1 -> HPREDUCING_P2
  - ANIMATION_P2 -> HPREDUCING_P1
REQ-021 On entry to ANIMATION_P2, the P2 skill is chosen (see Configuration) and its damage is latched.
REQ-022 In HPREDUCING_x, each tick decrements that player's HP by 1 and the remaining damage by 1; HP never goes below 0.
REQ-023 When that player's HP reaches 0: GAME_OVER, with winner = the other player; this takes priority over damage remaining.
REQ-024 Otherwise, when remaining damage reaches 0:
  - HPREDUCING_P2 -> ANIMATION_P2
  - HPREDUCING_P1 -> MENU with option_state=1
REQ-025 Damage table by skill 1..4: 10, 20, 35, 50; a skill with damage 0 leaves HPREDUCING on the next tick.
REQ-026 A tick coinciding with a key pulse: each is handled by its own rule in the same cycle; a state transition uses the post-transition state from the next cycle.
REQ-027 All outputs are registered; every transition takes effect one cycle after the triggering pulse.

Reset
REQ-028 While rst_n=0: fight_state=IDLE, option_state=1, both HP=0, winner=0, counters and latched damage=0, LFSR=8'hA5.
REQ-029 Reset asserted mid-battle aborts immediately to the reset values; no state is retained.

Configuration
REQ-030 P2_RANDOM_SKILL_EN defined: P2 skill = (LFSR[1:0])+1; the 8-bit Fibonacci LFSR (taps 8,6,5,4) advances every clk.
REQ-031 P2_RANDOM_SKILL_EN undefined: P2 skill = the P1 skill last latched; the LFSR is not instantiated.

Structure
REQ-032 Package fight_pkg holds state codes, option codes 1..4, the damage table and the LFSR seed.
REQ-033 One sub-module, fight_lfsr8 (enable, seed on reset), is instantiated only under P2_RANDOM_SKILL_EN.

Verification
REQ-034 Reset, then start with p1_init=100, p2_init=100 -> fight_state=1, both HP=100, option_state=1.
REQ-035 In MENU: right, down, left -> option_state 2, 4, 3; enter -> stays MENU; up then enter -> CHOOSING_SKILL.
REQ-036 Choose skill 3; feed 30 ticks then 35 ticks -> p2_cur_hp=65, state ANIMATION_P2 (macro undefined: P2 skill 3 -> p1_cur_hp ends at 65, MENU).
REQ-037 p2_init=20, P1 skill 4 -> p2_cur_hp reaches 0 after 20 reduce ticks, GAME_OVER, winner=1; further keys and ticks cause no change.
REQ-038 Assert rst_n=0 during HPREDUCING_P2 -> outputs return to IDLE values asynchronously; start restarts cleanly.
REQ-039 enter and right pulsed in the same cycle in CHOOSING_SKILL -> skill latched from the pre-cycle option_state, no cursor move.
